// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops, iterative shift-add multiply.
// Result, flags and Err are registered on the edge that enters DONE.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [3:0]       Sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic             Done,
    output logic             Busy,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output logic             Err
);

    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   mcand, acc, acc_nxt;
    logic [WIDTH-1:0]     mplier;
    logic [SW-1:0]        cnt;
    logic                 last;

    logic [SW-1:0]        sh;
    logic [WIDTH:0]       t;
    logic signed [WIDTH:0] ts;
    logic [WIDTH-1:0]     res;
    logic                 rc, rv, rerr;

    assign Busy    = (state != IDLE);
    assign Done    = (state == DONE);
    assign sh      = B[SW-1:0];
    assign last    = (cnt == SW'(WIDTH - 1));
    assign acc_nxt = mplier[0] ? acc + mcand : acc;

    always_ff @(posedge Clk) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = (Sel == 4'd8) ? MUL : DONE;
            MUL:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle operations; the shift forms keep one extra bit to catch the bit shifted out
    always_comb begin
        res  = '0;
        rc   = 1'b0;
        rv   = 1'b0;
        rerr = 1'b0;
        t    = '0;
        ts   = '0;
        case (Sel)
            4'd0: res = '0;
            4'd1: begin
                t   = {1'b0, A} + {1'b0, B};
                res = t[WIDTH-1:0];
                rc  = t[WIDTH];
                rv  = (A[WIDTH-1] == B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
            end
            4'd2: begin
                t   = {1'b0, A} - {1'b0, B};
                res = t[WIDTH-1:0];
                rc  = t[WIDTH];
                rv  = (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
            end
            4'd3: res = A;
            4'd4: res = A ^ B;
            4'd5: res = A | B;
            4'd6: res = A & B;
            4'd7: begin
                t   = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
                res = t[WIDTH-1:0];
                rc  = t[WIDTH];
                rv  = !A[WIDTH-1] && res[WIDTH-1];
            end
            4'd8: res = '0;
            4'd9: begin
                t   = {1'b0, A} << sh;
                res = t[WIDTH-1:0];
                rc  = t[WIDTH];
            end
            4'd10: begin
                t   = {A, 1'b0} >> sh;
                res = t[WIDTH:1];
                rc  = t[0];
            end
            4'd11: begin
                ts  = $signed({A, 1'b0}) >>> sh;
                res = ts[WIDTH:1];
                rc  = ts[0];
            end
            default: rerr = 1'b1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            Q      <= '0;
            Z      <= 1'b0;
            N      <= 1'b0;
            C      <= 1'b0;
            V      <= 1'b0;
            Err    <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    if (Sel == 4'd8) begin
                        mcand  <= {{WIDTH{1'b0}}, A};
                        mplier <= B;
                        acc    <= '0;
                        cnt    <= '0;
                    end else begin
                        Q   <= res;
                        Z   <= (res == '0);
                        N   <= res[WIDTH-1];
                        C   <= rc;
                        V   <= rv;
                        Err <= rerr;
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SW'(1);
                    if (last) begin
                        Q   <= acc_nxt[WIDTH-1:0];
                        Z   <= (acc_nxt[WIDTH-1:0] == '0);
                        N   <= acc_nxt[WIDTH-1];
                        C   <= |acc_nxt[2*WIDTH-1:WIDTH];
                        V   <= 1'b0;
                        Err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=16): vector table through a Done-driven scoreboard,
// plus hand sequences for reset, ignored Start during MUL and reset mid-MUL.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  sel;
    logic [15:0] a, b, q;
    logic        done, busy, z, n, c, v, err;

    alu_seq #(.WIDTH(16)) dut (
        .Clk(clk), .Reset_n(reset_n), .Start(start), .Sel(sel), .A(a), .B(b),
        .Q(q), .Done(done), .Busy(busy), .Z(z), .N(n), .C(c), .V(v), .Err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [4:0]  f;     // {Z,N,C,V,Err}
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] q;
        logic [4:0]  f;
        int          lat;
        int          c0;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[23];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   busy_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Scoreboard: every Done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_run++;
        else      busy_run = 0;
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("q", 32'(q), 32'(e.q));
                chk("flags_znvce", 32'({z, n, c, v, err}), 32'(e.f));
                chk("latency", 32'(cyc - e.c0), 32'(e.lat));
                chk("busy_len", 32'(busy_run), 32'(e.lat));
            end
        end
    end

    task automatic send(input logic [3:0] s, input logic [15:0] aa, input logic [15:0] bb,
                        input logic [15:0] eq, input logic [4:0] ef, input int lat, input bit push);
        @(negedge clk);
        start = 1'b1;
        sel   = s;
        a     = aa;
        b     = bb;
        if (push) sb.push_back('{q: eq, f: ef, lat: lat, c0: cyc});
        @(negedge clk);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        sel   = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_idle();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_q"}, 32'(q), 32'd0);
        chk({tag, "_flags"}, 32'({z, n, c, v, err}), 32'd0);
        chk({tag, "_busy_done"}, 32'({busy, done}), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{4'd1,  16'hFFFF, 16'h0001, 16'h0000, 5'b10100, 1};
        vecs[1]  = '{4'd2,  16'h8000, 16'h0001, 16'h7FFF, 5'b00010, 1};
        vecs[2]  = '{4'd11, 16'h8001, 16'h0001, 16'hC000, 5'b01100, 1};
        vecs[3]  = '{4'd8,  16'h0123, 16'h0010, 16'h1230, 5'b00000, 17};
        vecs[4]  = '{4'd8,  16'h1000, 16'h0010, 16'h0000, 5'b10100, 17};
        vecs[5]  = '{4'd13, 16'h1234, 16'h5678, 16'h0000, 5'b10001, 1};
        vecs[6]  = '{4'd3,  16'h00AA, 16'h5555, 16'h00AA, 5'b00000, 1};
        vecs[7]  = '{4'd1,  16'h7FFF, 16'h0001, 16'h8000, 5'b01010, 1};
        vecs[8]  = '{4'd2,  16'h0001, 16'h0002, 16'hFFFF, 5'b01100, 1};
        vecs[9]  = '{4'd4,  16'hF0F0, 16'h0FF0, 16'hFF00, 5'b01000, 1};
        vecs[10] = '{4'd5,  16'h1200, 16'h0034, 16'h1234, 5'b00000, 1};
        vecs[11] = '{4'd6,  16'hF0F0, 16'h3C3C, 16'h3030, 5'b00000, 1};
        vecs[12] = '{4'd7,  16'h7FFF, 16'h1234, 16'h8000, 5'b01010, 1};
        vecs[13] = '{4'd7,  16'hFFFF, 16'h0000, 16'h0000, 5'b10100, 1};
        vecs[14] = '{4'd0,  16'h1234, 16'h4321, 16'h0000, 5'b10000, 1};
        vecs[15] = '{4'd9,  16'h8001, 16'h0011, 16'h0002, 5'b00100, 1};
        vecs[16] = '{4'd9,  16'h1234, 16'h0000, 16'h1234, 5'b00000, 1};
        vecs[17] = '{4'd10, 16'h8009, 16'h0004, 16'h0800, 5'b00100, 1};
        vecs[18] = '{4'd11, 16'h8000, 16'h000F, 16'hFFFF, 5'b01000, 1};
        vecs[19] = '{4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 5'b10001, 1};
        vecs[20] = '{4'd8,  16'hFFFF, 16'hFFFF, 16'h0001, 5'b00100, 17};
        vecs[21] = '{4'd8,  16'h0000, 16'h1234, 16'h0000, 5'b10000, 17};
        vecs[22] = '{4'd10, 16'h8000, 16'h0010, 16'h8000, 5'b01000, 1};

        reset_n = 1'b0;
        start   = 1'b0;
        sel     = 4'd0;
        a       = 16'd0;
        b       = 16'd0;
        repeat (3) @(negedge clk);
        chk_cleared("por");
        reset_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            send(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].f, vecs[i].lat, 1'b1);
            wait_idle();
        end

        // MUL with a Start pulse in cycle 3 that must be ignored; Q holds meanwhile
        send(4'd8, 16'h0123, 16'h0010, 16'h1230, 5'b00000, 17, 1'b1);
        @(negedge clk);
        start = 1'b1;
        sel   = 4'd1;
        a     = 16'h0001;
        b     = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        chk("hold_q_mid_mul", 32'(q), 32'h8000);
        wait_idle();
        repeat (3) @(negedge clk);

        // Reset in the middle of a MUL, then a normal ADD
        send(4'd8, 16'h1234, 16'h5678, 16'h0, 5'b0, 17, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk_cleared("mid_mul_reset");
        reset_n = 1'b1;
        send(4'd1, 16'h0002, 16'h0003, 16'h0005, 5'b00000, 1, 1'b1);
        wait_idle();

        // Reset wins over Start on the same edge; no Done may follow
        @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b1;
        sel     = 4'd1;
        a       = 16'h0005;
        b       = 16'h0006;
        @(negedge clk);
        chk_cleared("reset_vs_start");
        reset_n = 1'b1;
        start   = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
